// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared definitions for the instruction-fetch stage: FSM state type,
//   default reset PC and the filler instruction used on fetch errors.
//   No ports; imported by ifu_fetch.
package ifu_fetch_pkg;

  // Fetch sequencer states. One instruction is handled at a time:
  // IDLE (post-reset settle), REQ (address out), WAIT (data back), HOLD (to decode).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0

  // Redirect targets are word addresses; the two low bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction-fetch stage feeding decode. Owns the fetch PC, issues one
//   32-bit read at a time on an AXI4-Lite-style read channel and presents
//   {inst, pc, inst_fault} to decode on a valid/ready handshake. Redirects
//   from the back end restart fetch; a read already in flight on the stale
//   path is completed on the bus and its data dropped.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   redirect_valid, redirect_pc one-cycle restart request and its target
//   arvalid, araddr, arready    read address channel
//   rvalid, rdata, rresp,rready read data channel (rresp != 0 = access fault)
//   inst, pc, inst_fault        fetched instruction record to decode
//   valid_next, ready_next      handshake with decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  output logic        valid_next,
  input  logic        ready_next
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  redirect_target;
  logic         capture;

  assign redirect_target = word_align(redirect_pc);

  // The read address is always the current fetch PC. fetch_pc only changes
  // outside REQ, so araddr is stable for the whole address phase.
  assign araddr = fetch_pc_q;

  // State, PC and pending-redirect registers. A redirect that arrives while a
  // read is on the bus cannot cancel it, so its target is parked in redir_pc
  // until the stale data returns and is thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  // Instruction record shown to decode. Loaded only when a non-stale read
  // completes; an errored read is replaced by a NOP and flagged so decode can
  // raise the fetch fault at the right PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= 32'h0000_0000;
      pc         <= 32'h0000_0000;
      inst_fault <= 1'b0;
    end else if (capture) begin
      inst       <= (rresp != 2'b00) ? NOP_INST : rdata;
      pc         <= fetch_pc_q;
      inst_fault <= (rresp != 2'b00);
    end
  end

  // Next-state logic. Handshake outputs decode the registered state only, so
  // there is no combinational path from rvalid/ready_next to arvalid/valid_next.
  // A redirect seen in the same cycle as returning read data skips the parking
  // register and goes straight to the new target; a newer redirect always
  // overwrites an older parked one.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    capture      = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    valid_next   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) fetch_pc_d = redirect_target;
      end

      S_REQ: begin
        arvalid = 1'b1;
        if (redirect_valid) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = redirect_target;
        end
        if (arready) state_d = S_WAIT;
      end

      S_WAIT: begin
        rready = 1'b1;
        if (rvalid) begin
          if (redirect_valid) begin
            fetch_pc_d   = redirect_target;
            redir_pend_d = 1'b0;
            state_d      = S_REQ;
          end else if (redir_pend_q) begin
            fetch_pc_d   = redir_pc_q;
            redir_pend_d = 1'b0;
            state_d      = S_REQ;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = redirect_target;
        end
      end

      S_HOLD: begin
        valid_next = 1'b1;
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = S_REQ;
        end else if (ready_next) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
//   Self-checking bench for ifu_fetch: a cycle table for the zero-wait
//   pipeline cadence, hand-written sequences for stalls, redirects, faults,
//   reset mid-read and PC wrap, then a randomized run against a behavioural
//   memory and a stream-level model of which PCs decode must receive.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        valid_next;
  logic        ready_next;

  int total = 0;
  int bad   = 0;

  ifu_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .inst(inst), .pc(pc), .inst_fault(inst_fault),
    .valid_next(valid_next), .ready_next(ready_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per cycle of the zero-wait cadence after reset release.
  typedef struct {
    logic        arr;
    logic        rv;
    logic        rn;
    logic        exp_arvalid;
    logic [31:0] exp_araddr;
    logic        exp_rready;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic memFault(input logic [31:0] a);
    return a[5:2] == 4'd7;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic arr, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rs, input logic rn,
                               input logic rdv, input logic [31:0] rdpc);
    arready        = arr;
    rvalid         = rv;
    rdata          = rd;
    rresp          = rs;
    ready_next     = rn;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_arvalid", {31'b0, arvalid}, 32'd0);
    checkOutput("rst_rready", {31'b0, rready}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid_next}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_fault", {31'b0, inst_fault}, 32'd0);
  endtask

  // Holds reset for two cycles, checks the reset values, releases on a falling
  // edge (optionally with a redirect during IDLE) and returns one cycle later.
  task automatic doReset(input logic rdv, input logic [31:0] rdpc);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs();
    rst_n          = 1'b1;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Serves exactly one fetch by hand and checks what decode is shown.
  task automatic serveFetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input logic [1:0] resp, input logic [31:0] exp_inst,
                            input logic exp_fault);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("arvalid_wait", {31'b0, arvalid}, 32'd1);
    checkOutput("araddr", araddr, exp_addr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = data;
    rresp   = resp;
    @(negedge clk);
    rvalid = 1'b0;
    n = 0;
    while (!valid_next && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_wait", {31'b0, valid_next}, 32'd1);
    checkOutput("inst", inst, exp_inst);
    checkOutput("pc", pc, exp_addr);
    checkOutput("inst_fault", {31'b0, inst_fault}, {31'b0, exp_fault});
    ready_next = 1'b1;
    @(negedge clk);
    ready_next = 1'b0;
    checkOutput("valid_drop", {31'b0, valid_next}, 32'd0);
  endtask

  // Randomized run: the testbench plays memory (random arready and latency,
  // faults on some addresses) and decode (random ready_next), and fires random
  // redirects. Expected stream: each delivered PC is the previous one plus 4,
  // unless a redirect happened after the previous delivery, in which case it is
  // the newest redirect target.
  task automatic runRandom(input int cycles);
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_delay;
    logic [31:0] exp_pc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    int          delivered;
    mem_busy   = 1'b0;
    mem_addr   = 32'd0;
    mem_delay  = 0;
    exp_pc     = RESET_PC;
    prev_stall = 1'b0;
    prev_addr  = 32'd0;
    delivered  = 0;
    for (int c = 0; c < cycles; c++) begin
      if (prev_stall) checkOutput("araddr_stable", araddr, prev_addr);
      if (mem_busy) begin
        arready = 1'b0;
        if (mem_delay == 0) begin
          rvalid = 1'b1;
          rdata  = memData(mem_addr);
          rresp  = memFault(mem_addr) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0;
          mem_delay--;
        end
      end else begin
        arready = ($urandom_range(0, 1) == 1);
        rvalid  = 1'b0;
      end
      ready_next = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else
          redirect_pc = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end

      if (arvalid && arready) begin
        mem_busy  = 1'b1;
        mem_addr  = araddr;
        mem_delay = $urandom_range(0, 3);
      end else if (rvalid && rready) begin
        mem_busy = 1'b0;
      end
      if (valid_next && ready_next) begin
        checkOutput("rnd_pc", pc, exp_pc);
        checkOutput("rnd_inst", inst, memFault(exp_pc) ? NOP_INST : memData(exp_pc));
        checkOutput("rnd_fault", {31'b0, inst_fault}, {31'b0, memFault(exp_pc)});
        delivered++;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    checkOutput("rnd_progress", {31'b0, delivered >= 100}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Zero-wait cadence: REQ, WAIT, HOLD repeating, pc advancing by 4.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h8000_0000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0000};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h8000_0004};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0004};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);

    $display("[TB] cadence table after reset");
    doReset(1'b0, 32'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].arr, vecs[i].rv, 32'h0010_0093, 2'b00, vecs[i].rn, 1'b0, 32'd0);
      checkOutput($sformatf("t1_arvalid_%0d", i), {31'b0, arvalid}, {31'b0, vecs[i].exp_arvalid});
      if (vecs[i].exp_arvalid)
        checkOutput($sformatf("t1_araddr_%0d", i), araddr, vecs[i].exp_araddr);
      checkOutput($sformatf("t1_rready_%0d", i), {31'b0, rready}, {31'b0, vecs[i].exp_rready});
      checkOutput($sformatf("t1_valid_%0d", i), {31'b0, valid_next}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("t1_pc_%0d", i), pc, vecs[i].exp_pc);
      if (vecs[i].exp_valid)
        checkOutput($sformatf("t1_inst_%0d", i), inst, 32'h0010_0093);
      @(negedge clk);
    end

    $display("[TB] decode stall in HOLD");
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_valid", {31'b0, valid_next}, 32'd1);
      checkOutput("t2_pc", pc, 32'h8000_0008);
      checkOutput("t2_inst", inst, 32'h0010_0093);
      checkOutput("t2_arvalid", {31'b0, arvalid}, 32'd0);
      if (k == 4) ready_next = 1'b1;
      @(negedge clk);
    end
    checkOutput("t2_next_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("t2_next_araddr", araddr, 32'h8000_000C);
    applyStimulus(1'b1, 1'b0, 32'hDEAD_0000, 2'b00, 1'b1, 1'b0, 32'd0);
    @(negedge clk);

    $display("[TB] redirect during WAIT");
    checkOutput("t3_rready", {31'b0, rready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'hDEAD_0000, 2'b00, 1'b1, 1'b1, 32'h8000_0100);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_valid_low", {31'b0, valid_next}, 32'd0);
      checkOutput("t3_rready_hold", {31'b0, rready}, 32'd1);
      if (k == 3) rvalid = 1'b1;
      @(negedge clk);
    end
    checkOutput("t3_valid_after", {31'b0, valid_next}, 32'd0);
    checkOutput("t3_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("t3_araddr", araddr, 32'h8000_0100);

    $display("[TB] redirect in HOLD with handshake, then in REQ without arready");
    applyStimulus(1'b1, 1'b1, 32'hAAAA_0001, 2'b00, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_valid", {31'b0, valid_next}, 32'd1);
    checkOutput("t4_pc", pc, 32'h8000_0100);
    checkOutput("t4_inst", inst, 32'hAAAA_0001);
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b1, 1'b1, 32'h8000_0203);
    @(negedge clk);
    checkOutput("t4_valid_once", {31'b0, valid_next}, 32'd0);
    checkOutput("t4_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("t4_araddr", araddr, 32'h8000_0200);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0300);
    @(negedge clk);
    redirect_valid = 1'b0;
    checkOutput("t4_stall_araddr", araddr, 32'h8000_0200);
    checkOutput("t4_stall_arvalid", {31'b0, arvalid}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'hBBBB_0002, 2'b00, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    arready = 1'b0;
    checkOutput("t4_stale_rready", {31'b0, rready}, 32'd1);
    @(negedge clk);
    rvalid = 1'b0;
    checkOutput("t4_stale_valid", {31'b0, valid_next}, 32'd0);
    checkOutput("t4_redir_araddr", araddr, 32'h8000_0300);

    $display("[TB] access fault");
    doReset(1'b1, 32'h8000_0040);
    serveFetch(32'h8000_0040, 32'hDEAD_BEEF, 2'b10, NOP_INST, 1'b1);
    serveFetch(32'h8000_0044, 32'h0000_0033, 2'b00, 32'h0000_0033, 1'b0);

    $display("[TB] reset mid-WAIT");
    begin : reset_mid_wait
      int n;
      n = 0;
      while (!arvalid && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("t6_arvalid_wait", {31'b0, arvalid}, 32'd1);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checkOutput("t6_rready", {31'b0, rready}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs();
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 2'b00, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_arvalid", {31'b0, arvalid}, 32'd1);
      checkOutput("t6_araddr", araddr, RESET_PC);
      checkOutput("t6_rready_low", {31'b0, rready}, 32'd0);
      checkOutput("t6_valid_low", {31'b0, valid_next}, 32'd0);
      @(negedge clk);
      checkOutput("t6_valid_still_low", {31'b0, valid_next}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
      serveFetch(RESET_PC, 32'h0000_0093, 2'b00, 32'h0000_0093, 1'b0);
    end

    $display("[TB] PC wrap");
    doReset(1'b1, 32'hFFFF_FFFC);
    serveFetch(32'hFFFF_FFFC, 32'h0000_1111, 2'b00, 32'h0000_1111, 1'b0);
    serveFetch(32'h0000_0000, 32'h0000_2222, 2'b00, 32'h0000_2222, 1'b0);

    $display("[TB] randomized run");
    doReset(1'b0, 32'd0);
    runRandom(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
